// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
//   Shared definitions for the UART transmit sequencer.
//   - state_t   : FSM state encoding (IDLE/START/DATA/PARITY/STOP[/STOP2])
//   - MUX_*     : TX output mux select codes driven to the datapath
//   - cnt_w()   : width helper for the data-bit counter
//   Build option: UART_TX_TWO_STOP_EN adds the STOP2 state (two stop bits).
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
`ifdef UART_TX_TWO_STOP_EN
        ,
        STOP2  = 3'd5
`endif
    } state_t;

    // Output mux select: which level the TX line carries this bit period.
    localparam logic [1:0] MUX_START = 2'b00;  // start bit, line low
    localparam logic [1:0] MUX_IDLE  = 2'b01;  // idle / stop bit, line high
    localparam logic [1:0] MUX_DATA  = 2'b10;  // serializer output
    localparam logic [1:0] MUX_PAR   = 2'b11;  // parity calculator output

    // Counter width for n data bits; never below 1 so a 1-bit frame still builds.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_cnt
//   Data-bit counter for the UART transmit sequencer.
//   Ports:
//     CLK       in  TX clock
//     RST       in  asynchronous active-low reset
//     clear     in  force count to 0 (wins over enable)
//     enable    in  advance count by one
//     last_bit  out count has reached Data_width-1 (terminal count)
// -----------------------------------------------------------------------------
module uart_tx_bit_cnt
    import uart_tx_pkg::*;
#(
    parameter int Data_width = 8,
    localparam int CW = cnt_w(Data_width)
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic last_bit
);

    logic [CW-1:0] bit_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
        end else if (enable) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign last_bit = (bit_cnt == CW'(Data_width - 1));

endmodule

// File: rtl/uart_tx_fsm.sv
// -----------------------------------------------------------------------------
// uart_tx_fsm
//   Sequencer for the UART TX datapath (serializer, parity calculator, output
//   mux). Steps the line through start, data, optional parity and stop bits,
//   one bit per baud tick.
//   Ports:
//     CLK         in   TX clock, posedge
//     RST         in   asynchronous active-low reset
//     Data_Vaild  in   frame request, accepted only in IDLE
//     PAR_EN      in   parity enable, captured on accept
//     bit_tick    in   one-cycle baud enable, ends the current bit period
//     ser_en      out  serializer shift pulse (DATA state, on bit_tick)
//     mux_sel     out  TX output mux select (see MUX_* in uart_tx_pkg)
//     Busy        out  high from START through the last stop bit
//   Build option: UART_TX_TWO_STOP_EN defined -> two stop bits (STOP2 state).
// -----------------------------------------------------------------------------
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int Data_width = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Data_Vaild,
    input  logic       PAR_EN,
    input  logic       bit_tick,
    output logic       ser_en,
    output logic [1:0] mux_sel,
    output logic       Busy
);

    state_t state;
    state_t next_state;
    logic   par_en_q;
    logic   cnt_clear;
    logic   cnt_en;
    logic   last_bit;

    uart_tx_bit_cnt #(
        .Data_width (Data_width)
    ) u_bit_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .last_bit (last_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Parity choice is frozen at accept so a mid-frame PAR_EN change is harmless.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q <= 1'b0;
        end else if (state == IDLE && Data_Vaild) begin
            par_en_q <= PAR_EN;
        end
    end

    // Moore decode of mux_sel/Busy; ser_en is the only output qualified by bit_tick.
    always_comb begin
        next_state = state;
        ser_en     = 1'b0;
        cnt_en     = 1'b0;
        cnt_clear  = 1'b0;
        mux_sel    = MUX_IDLE;
        Busy       = 1'b0;

        case (state)
            IDLE: begin
                // A tick arriving with the request is not counted: START
                // always lasts until the next tick.
                cnt_clear = 1'b1;
                if (Data_Vaild) begin
                    next_state = START;
                end
            end
            START: begin
                mux_sel = MUX_START;
                Busy    = 1'b1;
                if (bit_tick) begin
                    cnt_clear  = 1'b1;
                    next_state = DATA;
                end
            end
            DATA: begin
                mux_sel = MUX_DATA;
                Busy    = 1'b1;
                if (bit_tick) begin
                    ser_en = 1'b1;
                    cnt_en = 1'b1;
                    if (last_bit) begin
                        cnt_clear  = 1'b1;
                        next_state = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                mux_sel = MUX_PAR;
                Busy    = 1'b1;
                if (bit_tick) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                mux_sel = MUX_IDLE;
                Busy    = 1'b1;
                if (bit_tick) begin
`ifdef UART_TX_TWO_STOP_EN
                    next_state = STOP2;
`else
                    next_state = IDLE;
`endif
                end
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP2: begin
                mux_sel = MUX_IDLE;
                Busy    = 1'b1;
                if (bit_tick) begin
                    next_state = IDLE;
                end
            end
`endif
            default: begin
                // Unused encodings fall back to an idle line.
                cnt_clear  = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
module tb_uart_tx_fsm;
    import uart_tx_pkg::*;

    logic       CLK;
    logic       RST;
    logic       Data_Vaild;
    logic       PAR_EN;
    logic       bit_tick;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    uart_tx_fsm #(.Data_width(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Vaild (Data_Vaild),
        .PAR_EN     (PAR_EN),
        .bit_tick   (bit_tick),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       tk;
        logic [1:0] mux;
        logic       busy;
        logic       ser;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic dv, input logic pe, input logic tk,
                                input logic [1:0] mux, input logic busy, input logic ser);
        vec_t v;
        v.dv = dv; v.pe = pe; v.tk = tk; v.mux = mux; v.busy = busy; v.ser = ser;
        vecs.push_back(v);
    endfunction

    task automatic chk_idle(input string name);
        chk({name, "_mux"}, 32'(mux_sel), 32'(MUX_IDLE));
        chk({name, "_busy"}, 32'(Busy), 32'd0);
        chk({name, "_ser"}, 32'(ser_en), 32'd0);
    endtask

    // One frame with tick every 4 cycles; optional tick on the accept cycle
    // and optional noise (Data_Vaild during DATA, PAR_EN toggling).
    task automatic run_frame(input string name, input logic pe,
                             input bit tick_on_accept, input bit noise);
        int         ser_cnt = 0;
        int         bad_ser = 0;
        bit         seen_busy = 0;
        bit         done = 0;
        logic [1:0] seq[$];
        logic [1:0] exp_seq[$];

        exp_seq.push_back(MUX_START);
        for (int i = 0; i < 8; i++) exp_seq.push_back(MUX_DATA);
        if (pe) exp_seq.push_back(MUX_PAR);
        exp_seq.push_back(MUX_IDLE);
`ifdef UART_TX_TWO_STOP_EN
        exp_seq.push_back(MUX_IDLE);
`endif

        @(negedge CLK);
        Data_Vaild = 1'b1;
        PAR_EN     = pe;
        bit_tick   = tick_on_accept;
        #1;
        chk({name, "_accept_busy"}, 32'(Busy), 32'd0);
        chk({name, "_accept_ser"}, 32'(ser_en), 32'd0);

        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge CLK);
            bit_tick   = (cyc % 4 == 3);
            Data_Vaild = noise ? (mux_sel == MUX_DATA) : 1'b0;
            if (noise) PAR_EN = ~PAR_EN;
            #1;
            if (ser_en) ser_cnt++;
            if (ser_en && mux_sel != MUX_DATA) bad_ser++;
            if (Busy) seen_busy = 1;
            if (Busy && bit_tick) seq.push_back(mux_sel);
            if (seen_busy && !Busy) done = 1;
        end
        Data_Vaild = 1'b0;
        bit_tick   = 1'b0;
        PAR_EN     = 1'b0;

        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_ser_cnt"}, 32'(ser_cnt), 32'd8);
        chk({name, "_ser_outside_data"}, 32'(bad_ser), 32'd0);
        chk({name, "_busy_ticks"}, 32'(seq.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size(); i++) begin
            chk($sformatf("%s_mux_tick%0d", name, i),
                (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
        end
        chk({name, "_end_mux"}, 32'(mux_sel), 32'(MUX_IDLE));

        // No queued frame may start afterwards.
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            bit_tick = (i % 4 == 3);
            #1;
            chk({name, "_after_busy"}, 32'(Busy), 32'd0);
        end
        bit_tick = 1'b0;
    endtask

    initial begin
        Data_Vaild = 1'b0;
        PAR_EN     = 1'b0;
        bit_tick   = 1'b0;
        RST        = 1'b0;
        #1;
        chk_idle("reset_async");
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        // 1: idle for 20 cycles with no stimulus
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            chk_idle($sformatf("idle%0d", i));
        end

        // Table: tick every cycle; tick in IDLE ignored, dv+tick together,
        // PAR_EN change and dv during frame ignored.
        add(0, 0, 0, MUX_IDLE,  0, 0);
        add(0, 0, 1, MUX_IDLE,  0, 0);
        add(1, 1, 1, MUX_IDLE,  0, 0);
        add(0, 0, 0, MUX_START, 1, 0);
        add(0, 0, 1, MUX_START, 1, 0);
        add(0, 0, 0, MUX_DATA,  1, 0);
        for (int i = 0; i < 8; i++) add(i[0], i[1], 1, MUX_DATA, 1, 1);
        add(0, 0, 0, MUX_PAR,   1, 0);
        add(0, 0, 1, MUX_PAR,   1, 0);
        add(0, 0, 0, MUX_IDLE,  1, 0);
        add(1, 0, 1, MUX_IDLE,  1, 0);
`ifdef UART_TX_TWO_STOP_EN
        add(0, 0, 1, MUX_IDLE,  1, 0);
`endif
        add(0, 0, 0, MUX_IDLE,  0, 0);
        add(0, 0, 1, MUX_IDLE,  0, 0);
        add(0, 0, 0, MUX_IDLE,  0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            Data_Vaild = vecs[i].dv;
            PAR_EN     = vecs[i].pe;
            bit_tick   = vecs[i].tk;
            #1;
            chk($sformatf("vec%0d_mux", i), 32'(mux_sel), 32'(vecs[i].mux));
            chk($sformatf("vec%0d_busy", i), 32'(Busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_ser", i), 32'(ser_en), 32'(vecs[i].ser));
        end
        Data_Vaild = 1'b0;
        PAR_EN     = 1'b0;
        bit_tick   = 1'b0;

        // 2, 3: parity and no-parity frames
        run_frame("par", 1'b1, 1'b0, 1'b0);
        run_frame("nopar", 1'b0, 1'b0, 1'b0);

        // 4: noise during the frame
        run_frame("noise_par", 1'b1, 1'b0, 1'b1);
        run_frame("noise_nopar", 1'b0, 1'b0, 1'b1);

        // 6: request and tick together
        run_frame("dv_tick", 1'b1, 1'b1, 1'b0);

        // 5: reset during DATA bit 3
        begin
            int  ser_cnt = 0;
            bit  reached = 0;
            @(negedge CLK);
            Data_Vaild = 1'b1;
            PAR_EN     = 1'b1;
            #1;
            for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
                @(negedge CLK);
                Data_Vaild = 1'b0;
                bit_tick   = (cyc % 4 == 3);
                #1;
                if (ser_en) ser_cnt++;
                if (ser_cnt == 3) reached = 1;
            end
            chk("rst_reach_bit3", 32'(reached), 32'd1);
            @(negedge CLK);
            bit_tick = 1'b1;
            #1;
            chk("rst_pre_mux", 32'(mux_sel), 32'(MUX_DATA));
            RST = 1'b0;
            #1;
            chk_idle("rst_mid");
            @(negedge CLK);
            #1;
            chk_idle("rst_hold");
            bit_tick = 1'b0;
            RST      = 1'b1;
            run_frame("post_rst", 1'b1, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
